// File: rtl/crtc_pkg.sv
// crtc_pkg: CRTC register indices, reset defaults, raster state enum and sync helpers.
package crtc_pkg;
  localparam int R0 = 0, R1 = 1, R2 = 2, R3 = 3, R4 = 4, R5 = 5, R6 = 6, R7 = 7, R8 = 8;
  localparam int R9 = 9, R10 = 10, R11 = 11, R12 = 12, R13 = 13, R14 = 14, R15 = 15;
  localparam int R16 = 16, R17 = 17;
  localparam logic [7:0] R0_DEF = 8'h31, R1_DEF = 8'h28, R2_DEF = 8'h29, R3_DEF = 8'h0F;
  localparam logic [7:0] R4_DEF = 8'h28, R5_DEF = 8'h05, R6_DEF = 8'h19, R7_DEF = 8'h21;
  localparam logic [7:0] R8_DEF = 8'h00, R9_DEF = 8'h07, R10_DEF = 8'h00, R11_DEF = 8'h00;
  localparam logic [7:0] R12_DEF = 8'h00, R13_DEF = 8'h00, R14_DEF = 8'h00, R15_DEF = 8'h00;
  localparam logic [7:0] R16_DEF = 8'h00, R17_DEF = 8'h00;
  typedef enum logic {ACTIVE, ADJUST} crtc_state_t;
  // A programmed vsync width of 0 stands for the full 16 lines.
  function automatic logic [4:0] vsync_width(input logic [3:0] w);
    return (w == 4'd0) ? 5'd16 : {1'b0, w};
  endfunction
endpackage

// File: rtl/crtc_sync_pulse.sv
// crtc_sync_pulse: registered sync pulse lasting width ticks from a start strobe; width 0 gives no pulse.
module crtc_sync_pulse (
  input  logic       clk16,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [4:0] width,
  output logic       pulse
);
  logic [4:0] left, left_n;
  always_comb left_n = start ? width : (left != 5'd0) ? left - 5'd1 : 5'd0;
  always_ff @(posedge clk16 or posedge reset)
    if (reset) begin
      left  <= 5'd0;
      pulse <= 1'b0;
    end else if (tick) begin
      left  <= left_n;
      pulse <= left_n != 5'd0;
    end
endmodule

// File: rtl/crtc_timing.sv
// crtc_timing: 6545-compatible raster engine producing sync, display enable, MA and RA from live CRTC registers.
// Optional cursor output is built when CRTC_CURSOR_EN is defined.
module crtc_timing
  import crtc_pkg::*;
#(
  parameter int MA_WIDTH = 14,
  parameter int RA_WIDTH = 5
) (
  input  logic                clk16,
  input  logic                reset,
  input  logic                char_en,
  input  logic [7:0]          r0_h_total,
  input  logic [7:0]          r1_h_displayed,
  input  logic [7:0]          r2_hsync_pos,
  input  logic [7:0]          r3_sync_width,
  input  logic [6:0]          r4_v_total,
  input  logic [4:0]          r5_v_adjust,
  input  logic [6:0]          r6_v_displayed,
  input  logic [6:0]          r7_vsync_pos,
  input  logic [4:0]          r9_max_scan,
  input  logic [5:0]          r12_start_hi,
  input  logic [7:0]          r13_start_lo,
`ifdef CRTC_CURSOR_EN
  input  logic [6:0]          r10_cursor_start,
  input  logic [4:0]          r11_cursor_end,
  input  logic [5:0]          r14_cursor_hi,
  input  logic [7:0]          r15_cursor_lo,
  output logic                cursor,
`endif
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [MA_WIDTH-1:0] ma,
  output logic [RA_WIDTH-1:0] ra,
  output logic                frame_start
);
  crtc_state_t state, state_n;
  logic [7:0] h, h_n;
  logic [6:0] row, row_n;
  logic [RA_WIDTH-1:0] ra_n;
  logic [RA_WIDTH:0] ra_inc;
  logic [MA_WIDTH-1:0] row_start, row_start_n, ma_n, start_addr;
  logic fresh, line_end, row_last, adj_last, frame_end;
  logic de_n, hs_start, vs_start;
  assign start_addr = MA_WIDTH'({r12_start_hi, r13_start_lo});
  always_ff @(posedge clk16 or posedge reset)
    if (reset) state <= ACTIVE;
    else if (char_en) state <= state_n;
  // fresh marks the first char_en after reset, which opens a frame without advancing.
  always_comb begin
    line_end = h >= r0_h_total;
    row_last = ra >= RA_WIDTH'(r9_max_scan);
    ra_inc = {1'b0, ra} + (RA_WIDTH + 1)'(1);
    adj_last = ra_inc >= (RA_WIDTH + 1)'(r5_v_adjust);
    frame_end = line_end && ((state == ADJUST) ? adj_last
                : row_last && row >= r4_v_total && r5_v_adjust == 5'd0);
    state_n = state;
    h_n = line_end ? 8'd0 : h + 8'd1;
    ra_n = ra;
    row_n = row;
    row_start_n = row_start;
    if (fresh || frame_end) begin
      state_n = ACTIVE;
      h_n = 8'd0;
      ra_n = '0;
      row_n = 7'd0;
      row_start_n = start_addr;
    end else if (line_end) begin
      if (state == ADJUST || !row_last) ra_n = ra_inc[RA_WIDTH-1:0];
      else begin
        ra_n = '0;
        row_start_n = row_start + MA_WIDTH'(r1_h_displayed);
        if (row >= r4_v_total) state_n = ADJUST;
        else row_n = row + 7'd1;
      end
    end
  end
  always_comb begin
    ma_n = row_start_n + MA_WIDTH'(h_n);
    de_n = h_n < r1_h_displayed && row_n < r6_v_displayed && state_n == ACTIVE;
    hs_start = h_n == r2_hsync_pos;
    vs_start = (fresh || line_end) && state_n == ACTIVE && row_n == r7_vsync_pos && ra_n == '0;
  end
  always_ff @(posedge clk16 or posedge reset)
    if (reset) begin
      h <= 8'd0;
      ra <= '0;
      row <= 7'd0;
      row_start <= '0;
      fresh <= 1'b1;
      de <= 1'b0;
      ma <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= char_en && (fresh || frame_end);
      if (char_en) begin
        h <= h_n;
        ra <= ra_n;
        row <= row_n;
        row_start <= row_start_n;
        fresh <= 1'b0;
        de <= de_n;
        ma <= ma_n;
      end
    end
  crtc_sync_pulse u_hsync (
    .clk16(clk16),
    .reset(reset),
    .tick(char_en),
    .start(hs_start),
    .width({1'b0, r3_sync_width[3:0]}),
    .pulse(hsync)
  );
  crtc_sync_pulse u_vsync (
    .clk16(clk16),
    .reset(reset),
    .tick(char_en && (fresh || line_end)),
    .start(vs_start),
    .width(vsync_width(r3_sync_width[7:4])),
    .pulse(vsync)
  );
`ifdef CRTC_CURSOR_EN
  logic [5:0] frame_cnt;
  logic blink_ok, cursor_n;
  always_comb begin
    blink_ok = r10_cursor_start[6] ? (r10_cursor_start[5] ? frame_cnt[5] : frame_cnt[4])
             : !r10_cursor_start[5];
    cursor_n = de_n && ma_n == MA_WIDTH'({r14_cursor_hi, r15_cursor_lo})
             && RA_WIDTH'(r10_cursor_start[4:0]) <= ra_n && ra_n <= RA_WIDTH'(r11_cursor_end)
             && blink_ok;
  end
  always_ff @(posedge clk16 or posedge reset)
    if (reset) begin
      frame_cnt <= 6'd0;
      cursor <= 1'b0;
    end else if (char_en) begin
      cursor <= cursor_n;
      if (frame_end) frame_cnt <= frame_cnt + 6'd1;
    end
`endif
endmodule

// File: tb/tb_crtc_timing.sv
// tb_crtc_timing: directed checks of line, frame, address and reset behaviour of crtc_timing.
module tb_crtc_timing;
  logic clk16 = 1'b0, reset = 1'b1, char_en = 1'b0;
  logic [7:0] r0 = 8'd49, r1 = 8'd40, r2 = 8'd41, r3 = 8'h0F;
  logic [6:0] r4 = 7'd40, r6 = 7'd25, r7 = 7'd33;
  logic [4:0] r5 = 5'd5, r9 = 5'd7;
  logic [5:0] r12 = 6'd0;
  logic [7:0] r13 = 8'd0;
  logic hsync, vsync, de, frame_start;
  logic [13:0] ma;
  logic [4:0] ra;
  int compared = 0, mismatched = 0, gap = 1;

  crtc_timing #(.MA_WIDTH(14), .RA_WIDTH(5)) dut (
    .clk16(clk16), .reset(reset), .char_en(char_en),
    .r0_h_total(r0), .r1_h_displayed(r1), .r2_hsync_pos(r2), .r3_sync_width(r3),
    .r4_v_total(r4), .r5_v_adjust(r5), .r6_v_displayed(r6), .r7_vsync_pos(r7),
    .r9_max_scan(r9), .r12_start_hi(r12), .r13_start_lo(r13),
    .hsync(hsync), .vsync(vsync), .de(de), .ma(ma), .ra(ra), .frame_start(frame_start)
  );

  always #5 clk16 = ~clk16;

  task automatic tick();
    char_en = 1'b1;
    @(negedge clk16);
    char_en = 1'b0;
    repeat (gap - 1) @(negedge clk16);
  endtask

  task automatic do_reset();
    @(negedge clk16);
    reset = 1'b1;
    @(negedge clk16);
    reset = 1'b0;
  endtask

  task automatic run_frame(output int len, output int de_cnt, output int vs_first,
                           output int vs_cnt, output int ra327, output int ra328,
                           output int ra332, output int de328);
    len = -1; de_cnt = 0; vs_first = -1; vs_cnt = 0;
    ra327 = -1; ra328 = -1; ra332 = -1; de328 = -1;
    do_reset();
    for (int k = 0; k < 20000; k++) begin
      tick();
      if (k > 0 && frame_start) begin
        len = k;
        break;
      end
      de_cnt += int'(de);
      if (vsync) begin
        if (vs_first < 0) vs_first = k;
        vs_cnt++;
      end
      if (k == 327 * 50) ra327 = int'(ra);
      if (k == 328 * 50) begin
        ra328 = int'(ra);
        de328 = int'(de);
      end
      if (k == 332 * 50) ra332 = int'(ra);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk16);
    compared++;
    if ({hsync, vsync, de, frame_start} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_flags: got %b want 0000", {hsync, vsync, de, frame_start});
    end
    compared++;
    if (ma !== 14'h0 || ra !== 5'd0) begin
      mismatched++;
      $display("FAIL reset_ma_ra: got ma=%h ra=%0d want 0/0", ma, ra);
    end
  endtask

  task automatic test_first_tick_and_freeze();
    gap = 1;
    reset = 1'b0;
    tick();
    compared++;
    if (frame_start !== 1'b1 || de !== 1'b1 || ma !== 14'h0) begin
      mismatched++;
      $display("FAIL first_tick: got fs=%b de=%b ma=%h want 1/1/0", frame_start, de, ma);
    end
    @(negedge clk16);
    compared++;
    if (frame_start !== 1'b0) begin
      mismatched++;
      $display("FAIL frame_start_width: got %b want 0", frame_start);
    end
    repeat (40) @(negedge clk16);
    compared++;
    if (de !== 1'b1 || ma !== 14'h0 || hsync !== 1'b0) begin
      mismatched++;
      $display("FAIL freeze: got de=%b ma=%h hs=%b want 1/0/0", de, ma, hsync);
    end
  endtask

  task automatic test_line_timing();
    gap = 16;
    for (int k = 1; k < 60; k++) begin
      tick();
      compared++;
      if (de !== ((k % 50) < 40)) begin
        mismatched++;
        $display("FAIL line_de k=%0d: got %b want %b", k, de, (k % 50) < 40);
      end
      compared++;
      if (hsync !== (k >= 41 && k <= 55)) begin
        mismatched++;
        $display("FAIL line_hsync k=%0d: got %b want %b", k, hsync, k >= 41 && k <= 55);
      end
    end
    gap = 1;
  endtask

  task automatic test_frame();
    int len, de_cnt, vs_first, vs_cnt, ra327, ra328, ra332, de328;
    run_frame(len, de_cnt, vs_first, vs_cnt, ra327, ra328, ra332, de328);
    compared++;
    if (len != 16650) begin
      mismatched++;
      $display("FAIL frame_len: got %0d want 16650", len);
    end
    compared++;
    if (de_cnt != 8000) begin
      mismatched++;
      $display("FAIL frame_de_count: got %0d want 8000", de_cnt);
    end
    compared++;
    if (vs_first != 13200 || vs_cnt != 800) begin
      mismatched++;
      $display("FAIL frame_vsync: got first=%0d count=%0d want 13200/800", vs_first, vs_cnt);
    end
    compared++;
    if (ra327 != 7 || ra328 != 0 || ra332 != 4 || de328 != 0) begin
      mismatched++;
      $display("FAIL frame_adjust: got ra=%0d/%0d/%0d de=%0d want 7/0/4 de=0",
               ra327, ra328, ra332, de328);
    end
  endtask

  task automatic test_address();
    r12 = 6'h01; r13 = 8'h00;
    do_reset();
    for (int k = 0; k <= 400; k++) begin
      tick();
      if (k == 0 || k == 39 || k == 40 || k == 350 || k == 400) begin
        logic [13:0] ma_x;
        logic [4:0] ra_x;
        ma_x = (k == 0 || k == 350) ? 14'h100 : (k == 39) ? 14'h127 : 14'h128;
        ra_x = (k == 350) ? 5'd7 : 5'd0;
        compared++;
        if (ma !== ma_x || ra !== ra_x || de !== (k != 40)) begin
          mismatched++;
          $display("FAIL address k=%0d: got ma=%h ra=%0d de=%b want ma=%h ra=%0d de=%b",
                   k, ma, ra, de, ma_x, ra_x, k != 40);
        end
      end
    end
  endtask

  task automatic test_wrap();
    r12 = 6'h3F; r13 = 8'hF0;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        compared++;
        if (ma !== 14'h3FFF) begin
          mismatched++;
          $display("FAIL wrap_top: got %h want 3fff", ma);
        end
      end
    end
    compared++;
    if (ma !== 14'h0000 || de !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_zero: got ma=%h de=%b want 0000/1", ma, de);
    end
    r12 = 6'h0; r13 = 8'h0;
  endtask

  task automatic test_no_hsync();
    int hs_cnt = 0;
    r3 = 8'h00;
    do_reset();
    for (int k = 0; k < 120; k++) begin
      tick();
      hs_cnt += int'(hsync);
    end
    compared++;
    if (hs_cnt != 0) begin
      mismatched++;
      $display("FAIL no_hsync: got %0d high ticks want 0", hs_cnt);
    end
    r3 = 8'h0F;
  endtask

  task automatic test_no_adjust();
    int len, de_cnt, vs_first, vs_cnt, ra327, ra328, ra332, de328;
    r5 = 5'd0;
    run_frame(len, de_cnt, vs_first, vs_cnt, ra327, ra328, ra332, de328);
    compared++;
    if (len != 16400) begin
      mismatched++;
      $display("FAIL no_adjust_len: got %0d want 16400", len);
    end
    r5 = 5'd5;
  endtask

  task automatic test_r0_change();
    do_reset();
    for (int k = 0; k <= 30; k++) tick();
    r0 = 8'd20;
    tick();
    compared++;
    if (ma !== 14'd0 || ra !== 5'd1) begin
      mismatched++;
      $display("FAIL r0_wrap: got ma=%0d ra=%0d want 0/1", ma, ra);
    end
    repeat (20) tick();
    compared++;
    if (ma !== 14'd20 || ra !== 5'd1 || de !== 1'b1) begin
      mismatched++;
      $display("FAIL r0_line_end: got ma=%0d ra=%0d de=%b want 20/1/1", ma, ra, de);
    end
    tick();
    compared++;
    if (ma !== 14'd0 || ra !== 5'd2) begin
      mismatched++;
      $display("FAIL r0_next_line: got ma=%0d ra=%0d want 0/2", ma, ra);
    end
    r0 = 8'd49;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int k = 0; k <= 1217; k++) tick();
    compared++;
    if (ma !== 14'd137 || de !== 1'b1 || ra !== 5'd0) begin
      mismatched++;
      $display("FAIL midframe_pre: got ma=%0d de=%b ra=%0d want 137/1/0", ma, de, ra);
    end
    reset = 1'b1;
    #1;
    compared++;
    if ({hsync, vsync, de, frame_start} !== 4'b0000 || ma !== 14'h0 || ra !== 5'd0) begin
      mismatched++;
      $display("FAIL midframe_reset: got flags=%b ma=%h ra=%0d want 0/0/0",
               {hsync, vsync, de, frame_start}, ma, ra);
    end
    @(negedge clk16);
    r12 = 6'h02; r13 = 8'h00;
    reset = 1'b0;
    @(negedge clk16);
    tick();
    compared++;
    if (de !== 1'b1 || ma !== 14'h200 || frame_start !== 1'b1) begin
      mismatched++;
      $display("FAIL midframe_restart: got de=%b ma=%h fs=%b want 1/200/1", de, ma, frame_start);
    end
  endtask

  initial begin
    test_reset();
    test_first_tick_and_freeze();
    test_line_timing();
    test_frame();
    test_address();
    test_wrap();
    test_no_hsync();
    test_no_adjust();
    test_r0_change();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
